// File: rtl/oneshot_multi.sv
// Multi-channel edge-triggered one-shot with width, guard gap and retrigger.
// Define ONESHOT_MULTI_SYNC_EN to add a 2-flop trig synchronizer.
module oneshot_multi #(
  parameter int CH     = 4,
  parameter int PW_W   = 8,
  parameter int GAP    = 0,
  parameter int RETRIG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     trig,
  input  logic [2*CH-1:0]   edge_sel,
  input  logic [PW_W-1:0]   pw,
  input  logic [CH-1:0]     clr_miss,
  output logic [CH-1:0]     shot,
  output logic [CH-1:0]     busy,
  output logic [CH-1:0]     miss
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GUARD
  } st_t;

  localparam logic [PW_W-1:0] GAP_LD =
    PW_W'(GAP > 0 ? GAP - 1 : 0);

  logic [CH-1:0]   tin;
  logic [CH-1:0]   hist;
  logic [CH-1:0]   rise;
  logic [CH-1:0]   fall;
  logic [1:0]      arm_cnt;
  logic            armed;
  logic [PW_W-1:0] ld;

`ifdef ONESHOT_MULTI_SYNC_EN
  localparam int ARM_N = 3;
  logic [CH-1:0] s1;
  logic [CH-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= trig;
      s2 <= s1;
    end
  end

  assign tin = s2;
`else
  localparam int ARM_N = 1;
  assign tin = trig;
`endif

  // armed rises only after the input pipeline holds real samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      hist <= tin;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
        armed   <= (arm_cnt == 2'(ARM_N - 1));
      end
    end
  end

  assign rise = tin & ~hist;
  assign fall = ~tin & hist;
  assign ld   = (pw == '0) ? '0 : pw - 1'b1;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    st_t             st;
    st_t             st_n;
    logic [PW_W-1:0] cnt;
    logic [PW_W-1:0] cnt_n;
    logic            hit;
    logic            set;
    logic            shot_q;
    logic            busy_q;
    logic            miss_q;

    always_comb begin
      hit = 1'b0;
      unique case (edge_sel[2*i +: 2])
        2'b00: hit = rise[i];
        2'b01: hit = fall[i];
        2'b10: hit = rise[i] | fall[i];
        2'b11: hit = 1'b0;
      endcase
      hit = hit & armed;
    end

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      set   = 1'b0;
      unique case (st)
        IDLE: begin
          if (hit) begin
            st_n  = PULSE;
            cnt_n = ld;
          end
        end
        PULSE: begin
          if (hit && RETRIG != 0) begin
            cnt_n = ld;
          end else begin
            set = hit;
            if (cnt == '0) begin
              st_n  = (GAP > 0) ? GUARD : IDLE;
              cnt_n = GAP_LD;
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end
        GUARD: begin
          set = hit;
          if (cnt == '0) begin
            st_n = IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: st_n = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        cnt    <= '0;
        shot_q <= 1'b0;
        busy_q <= 1'b0;
        miss_q <= 1'b0;
      end else begin
        st     <= st_n;
        cnt    <= cnt_n;
        shot_q <= (st_n == PULSE);
        busy_q <= (st_n != IDLE);
        miss_q <= set | (miss_q & ~clr_miss[i]);
      end
    end

    assign shot[i] = shot_q;
    assign busy[i] = busy_q;
    assign miss[i] = miss_q;
  end

endmodule
